// File: rtl/cluster_periph_demux.sv
// Cluster peripheral-bus demux: routes one master port to NB_SPERIPHS slave plugs by address field,
// keeps responses in order through a route FIFO and answers unmapped slots with an error response.
module cluster_periph_demux #(
  parameter int unsigned                   NB_SPERIPHS     = 11,
  parameter int unsigned                   ADDR_WIDTH      = 32,
  parameter int unsigned                   DATA_WIDTH      = 32,
  parameter int unsigned                   BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned                   ID_WIDTH        = 5,
  parameter int unsigned                   ROUTE_LSB       = 10,
  parameter int unsigned                   ROUTE_WIDTH     = 4,
  parameter logic [NB_SPERIPHS-1:0]        SLAVE_EN_MASK   = 11'b111_1111_0111,
  parameter int unsigned                   MAX_OUTSTANDING = 4,
  parameter logic [DATA_WIDTH-1:0]         ERR_RDATA       = 32'hBADACCE5
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   mst_req_i,
  input  logic [ADDR_WIDTH-1:0]                  mst_add_i,
  input  logic                                   mst_wen_i,
  input  logic [DATA_WIDTH-1:0]                  mst_wdata_i,
  input  logic [BE_WIDTH-1:0]                    mst_be_i,
  input  logic [ID_WIDTH-1:0]                    mst_id_i,
  output logic                                   mst_gnt_o,
  output logic                                   mst_r_valid_o,
  output logic                                   mst_r_opc_o,
  output logic [DATA_WIDTH-1:0]                  mst_r_rdata_o,
  output logic [ID_WIDTH-1:0]                    mst_r_id_o,
  output logic [NB_SPERIPHS-1:0]                 slv_req_o,
  output logic [ADDR_WIDTH-1:0]                  slv_add_o,
  output logic                                   slv_wen_o,
  output logic [DATA_WIDTH-1:0]                  slv_wdata_o,
  output logic [BE_WIDTH-1:0]                    slv_be_o,
  output logic [ID_WIDTH-1:0]                    slv_id_o,
  input  logic [NB_SPERIPHS-1:0]                 slv_gnt_i,
  input  logic [NB_SPERIPHS-1:0]                 slv_r_valid_i,
  input  logic [NB_SPERIPHS-1:0]                 slv_r_opc_i,
  input  logic [NB_SPERIPHS*DATA_WIDTH-1:0]      slv_r_rdata_i,
  input  logic [NB_SPERIPHS*ID_WIDTH-1:0]        slv_r_id_i,
  output logic [$clog2(MAX_OUTSTANDING):0]       outstanding_o,
  output logic                                   proto_err_o
);

  localparam int unsigned      TGT_W   = $clog2(NB_SPERIPHS + 1);
  localparam int unsigned      PTR_W   = $clog2(MAX_OUTSTANDING);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(NB_SPERIPHS);

  logic [TGT_W-1:0]       fifo_q [MAX_OUTSTANDING];
  logic [TGT_W-1:0]       fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TGT_W-1:0]       last_target_q, last_target_d;
  logic                   err_valid_q, err_valid_d;
  logic [ID_WIDTH-1:0]    err_id_q, err_id_d;
  logic                   proto_err_q, proto_err_d;

  logic [ROUTE_WIDTH-1:0] route_idx;
  logic                   mapped;
  logic [TGT_W-1:0]       target;
  logic [TGT_W-1:0]       head;
  logic                   empty, full, allowed, push, pop, stray;
  logic                   unused_addr;

  assign route_idx   = mst_add_i[ROUTE_LSB +: ROUTE_WIDTH];
  assign unused_addr = ^mst_add_i;

  assign slv_add_o   = mst_add_i;
  assign slv_wen_o   = mst_wen_i;
  assign slv_wdata_o = mst_wdata_i;
  assign slv_be_o    = mst_be_i;
  assign slv_id_o    = mst_id_i;

  assign head          = fifo_q[rd_ptr_q];
  assign empty         = (cnt_q == '0);
  assign full          = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign outstanding_o = cnt_q;
  assign proto_err_o   = proto_err_q;

  // Address decode: unpopulated or out-of-range slots go to the internal error target
  always_comb begin
    mapped = 1'b0;
    target = ERR_TGT;
    for (int unsigned i = 0; i < NB_SPERIPHS; i++) begin
      if (32'(route_idx) == i && SLAVE_EN_MASK[i]) begin
        mapped = 1'b1;
        target = TGT_W'(i);
      end
    end
  end

  // A new target may only be issued once all responses of the previous target are back
  assign allowed = !full && (empty || target == last_target_q);

  always_comb begin
    slv_req_o = '0;
    mst_gnt_o = 1'b0;
    if (allowed) begin
      if (mapped) begin
        for (int unsigned i = 0; i < NB_SPERIPHS; i++) begin
          if (TGT_W'(i) == target) begin
            slv_req_o[i] = mst_req_i;
            mst_gnt_o    = slv_gnt_i[i];
          end
        end
      end else begin
        mst_gnt_o = mst_req_i;
      end
    end
  end

  assign push = mst_req_i && mst_gnt_o;

  // Response mux selected by the oldest outstanding target
  always_comb begin
    mst_r_valid_o = 1'b0;
    mst_r_opc_o   = 1'b0;
    mst_r_rdata_o = '0;
    mst_r_id_o    = '0;
    if (!empty) begin
      if (head == ERR_TGT) begin
        mst_r_valid_o = err_valid_q;
        mst_r_opc_o   = 1'b1;
        mst_r_rdata_o = ERR_RDATA;
        mst_r_id_o    = err_id_q;
      end else begin
        for (int unsigned i = 0; i < NB_SPERIPHS; i++) begin
          if (TGT_W'(i) == head) begin
            mst_r_valid_o = slv_r_valid_i[i];
            mst_r_opc_o   = slv_r_opc_i[i];
            mst_r_rdata_o = slv_r_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            mst_r_id_o    = slv_r_id_i[i*ID_WIDTH +: ID_WIDTH];
          end
        end
      end
    end
  end

  assign pop = mst_r_valid_o;

  always_comb begin
    stray = 1'b0;
    for (int unsigned i = 0; i < NB_SPERIPHS; i++) begin
      if (slv_r_valid_i[i] && (empty || head != TGT_W'(i))) stray = 1'b1;
    end
  end

  always_comb begin
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q + PTR_W'(push);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    cnt_d         = cnt_q + CNT_W'(push) - CNT_W'(pop);
    last_target_d = last_target_q;
    err_valid_d   = push && !mapped;
    err_id_d      = err_id_q;
    proto_err_d   = proto_err_q | stray;
    if (push) begin
      fifo_d[wr_ptr_q] = target;
      last_target_d    = target;
      if (!mapped) err_id_d = mst_id_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      last_target_q <= '0;
      err_valid_q   <= 1'b0;
      err_id_q      <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      last_target_q <= last_target_d;
      err_valid_q   <= err_valid_d;
      err_id_q      <= err_id_d;
      proto_err_q   <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_cluster_periph_demux.sv
// Bench for cluster_periph_demux: directed scenarios plus random traffic against a queue-based model.
module tb_cluster_periph_demux;

  localparam int NB    = 11;
  localparam int DW    = 32;
  localparam int IW    = 5;
  localparam int ERR_T = -1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            mst_req_i = 1'b0;
  logic [31:0]     mst_add_i = '0;
  logic            mst_wen_i = 1'b0;
  logic [31:0]     mst_wdata_i = '0;
  logic [3:0]      mst_be_i = '0;
  logic [4:0]      mst_id_i = '0;
  logic            mst_gnt_o, mst_r_valid_o, mst_r_opc_o;
  logic [31:0]     mst_r_rdata_o;
  logic [4:0]      mst_r_id_o;
  logic [NB-1:0]   slv_req_o;
  logic [31:0]     slv_add_o;
  logic            slv_wen_o;
  logic [31:0]     slv_wdata_o;
  logic [3:0]      slv_be_o;
  logic [4:0]      slv_id_o;
  logic [NB-1:0]   slv_gnt_i = '0, slv_r_valid_i = '0, slv_r_opc_i = '0;
  logic [NB*DW-1:0] slv_r_rdata_i = '0;
  logic [NB*IW-1:0] slv_r_id_i = '0;
  logic [2:0]      outstanding_o;
  logic            proto_err_o;

  cluster_periph_demux dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mst_req_i(mst_req_i), .mst_add_i(mst_add_i), .mst_wen_i(mst_wen_i),
    .mst_wdata_i(mst_wdata_i), .mst_be_i(mst_be_i), .mst_id_i(mst_id_i),
    .mst_gnt_o(mst_gnt_o), .mst_r_valid_o(mst_r_valid_o), .mst_r_opc_o(mst_r_opc_o),
    .mst_r_rdata_o(mst_r_rdata_o), .mst_r_id_o(mst_r_id_o),
    .slv_req_o(slv_req_o), .slv_add_o(slv_add_o), .slv_wen_o(slv_wen_o),
    .slv_wdata_o(slv_wdata_o), .slv_be_o(slv_be_o), .slv_id_o(slv_id_o),
    .slv_gnt_i(slv_gnt_i), .slv_r_valid_i(slv_r_valid_i), .slv_r_opc_i(slv_r_opc_i),
    .slv_r_rdata_i(slv_r_rdata_i), .slv_r_id_i(slv_r_id_i),
    .outstanding_o(outstanding_o), .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int tgt; logic [4:0] id; } ent_t;
  ent_t mq[$];
  int   last_tgt;
  bit   m_proto;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rdata = '0;
  bit          last_acc, seen_gnt, seen_rv, seen_opc;
  logic [NB-1:0] seen_req;
  logic [31:0] seen_rdata;
  logic [4:0]  seen_id;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Slots 0..10 are populated except reserved slot 3; everything else hits the error slave
  function automatic int target_of(input logic [31:0] a);
    int idx;
    idx = 32'(a[13:10]);
    if (idx < NB && idx != 3) return idx;
    return ERR_T;
  endfunction

  // Drive one cycle of stimulus, compare mid-cycle against the model, then advance the model
  task automatic cycle(input bit req, input logic [31:0] addr, input logic [4:0] id,
                       input logic [NB-1:0] gnt, input logic [NB-1:0] rv);
    int t, h;
    bit allowed, exp_gnt, exp_rv;
    logic [NB-1:0] exp_req;
    ent_t e;
    mst_req_i   = req;
    mst_add_i   = addr;
    mst_id_i    = id;
    mst_wen_i   = 1'($urandom);
    mst_wdata_i = $urandom;
    mst_be_i    = 4'($urandom);
    slv_gnt_i   = gnt;
    slv_r_valid_i = rv;
    slv_r_opc_i = 11'($urandom);
    for (int j = 0; j < NB; j++) begin
      slv_r_rdata_i[j*DW +: DW] = use_fixed ? fixed_rdata : $urandom;
      slv_r_id_i[j*IW +: IW]    = 5'($urandom);
    end
    if (mq.size() > 0 && mq[0].tgt != ERR_T) slv_r_id_i[mq[0].tgt*IW +: IW] = mq[0].id;
    #4;
    t = target_of(addr);
    allowed = (mq.size() < 4) && (mq.size() == 0 || t == last_tgt);
    exp_gnt = 1'b0;
    exp_req = '0;
    if (allowed) begin
      if (t == ERR_T) exp_gnt = req;
      else begin
        exp_gnt = gnt[t];
        exp_req[t] = req;
      end
    end
    seen_gnt = mst_gnt_o; seen_req = slv_req_o; seen_rv = mst_r_valid_o;
    seen_opc = mst_r_opc_o; seen_rdata = mst_r_rdata_o; seen_id = mst_r_id_o;
    check_val("gnt", mst_gnt_o, exp_gnt);
    check_val("slv_req", slv_req_o, exp_req);
    check_val("bcast", {slv_add_o, slv_id_o}, {addr, id});
    check_val("outstanding", outstanding_o, mq.size());
    check_val("proto_err", proto_err_o, m_proto);
    exp_rv = 1'b0;
    if (mq.size() > 0) begin
      h = mq[0].tgt;
      exp_rv = (h == ERR_T) ? 1'b1 : rv[h];
    end
    check_val("r_valid", mst_r_valid_o, exp_rv);
    if (exp_rv) begin
      if (h == ERR_T) begin
        check_val("r_opc", mst_r_opc_o, 1'b1);
        check_val("r_rdata", mst_r_rdata_o, 32'hBADACCE5);
      end else begin
        check_val("r_opc", mst_r_opc_o, slv_r_opc_i[h]);
        check_val("r_rdata", mst_r_rdata_o, slv_r_rdata_i[h*DW +: DW]);
      end
      check_val("r_id", mst_r_id_o, mq[0].id);
    end
    for (int j = 0; j < NB; j++)
      if (rv[j] && !(mq.size() > 0 && mq[0].tgt == j)) m_proto = 1'b1;
    if (exp_rv) void'(mq.pop_front());
    last_acc = req && exp_gnt;
    if (last_acc) begin
      e.tgt = t;
      e.id  = id;
      mq.push_back(e);
      last_tgt = t;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    mst_req_i = 1'b0; slv_gnt_i = '0; slv_r_valid_i = '0;
    rst_i = 1'b1;
    #4;
    mq.delete();
    m_proto  = 1'b0;
    last_tgt = 0;
    check_val("rst_outstanding", outstanding_o, 0);
    check_val("rst_r_valid", mst_r_valid_o, 0);
    check_val("rst_r_opc", mst_r_opc_o, 0);
    check_val("rst_r_rdata", mst_r_rdata_o, 0);
    check_val("rst_r_id", mst_r_id_o, 0);
    check_val("rst_proto_err", proto_err_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  localparam logic [31:0] A6 = 32'h0000_1800;
  localparam logic [31:0] A7 = 32'h0000_1C00;

  initial begin
    int idxs[8];
    bit have;
    logic [31:0] ra;
    logic [4:0]  rid;
    logic [NB-1:0] rrv;
    idxs = '{0, 1, 2, 3, 6, 7, 12, 15};
    #1;
    do_reset();

    // Mapped read to slot 1, response next cycle
    cycle(1'b1, 32'h1020_0400, 5'd1, 11'b000_0000_0010, '0);
    check_val("t1_slv_req", seen_req, 11'b000_0000_0010);
    use_fixed = 1'b1; fixed_rdata = 32'h1234;
    cycle(1'b0, '0, '0, '0, 11'b000_0000_0010);
    use_fixed = 1'b0;
    check_val("t1_rdata", seen_rdata, 32'h1234);
    cycle(1'b0, '0, '0, '0, '0);

    // Reserved slot 3 and out-of-range slot 12 both hit the error slave
    cycle(1'b1, 32'h0000_0C00, 5'h0A, '0, '0);
    check_val("t2_gnt", seen_gnt, 1'b1);
    check_val("t2_no_req", seen_req, '0);
    cycle(1'b0, '0, '0, '0, '0);
    check_val("t2_opc", seen_opc, 1'b1);
    check_val("t2_rdata", seen_rdata, 32'hBADACCE5);
    check_val("t2_id", seen_id, 5'h0A);
    cycle(1'b1, 32'h0000_3000, 5'h13, '0, '0);
    cycle(1'b1, 32'h0000_3000, 5'h14, '0, '0);
    check_val("t3_id", seen_id, 5'h13);
    cycle(1'b0, '0, '0, '0, '0);
    check_val("t3_id2", seen_id, 5'h14);
    check_val("t3_proto", proto_err_o, 1'b0);

    // Fill the route FIFO on slot 6
    for (int i = 0; i < 4; i++) cycle(1'b1, A6, 5'(i), 11'h040, '0);
    cycle(1'b1, A6, 5'd4, 11'h040, '0);
    check_val("t4_full_gnt", seen_gnt, 1'b0);
    check_val("t4_full_cnt", outstanding_o, 4);
    cycle(1'b1, A6, 5'd4, 11'h040, 11'h040);
    cycle(1'b1, A6, 5'd4, 11'h040, 11'h040);
    check_val("t4_pushpop", outstanding_o, 3);
    while (mq.size() > 0) cycle(1'b0, '0, '0, '0, 11'h040);

    // Target switch waits for drain
    cycle(1'b1, A6, 5'd8, 11'h040, '0);
    cycle(1'b1, A6, 5'd9, 11'h040, '0);
    cycle(1'b1, A7, 5'd10, '1, 11'h040);
    check_val("t5_block_gnt", seen_gnt, 1'b0);
    check_val("t5_block_req", seen_req, '0);
    cycle(1'b1, A7, 5'd10, '1, 11'h040);
    cycle(1'b1, A7, 5'd10, '1, '0);
    check_val("t5_granted", seen_gnt, 1'b1);
    cycle(1'b0, '0, '0, '0, 11'h080);
    cycle(1'b0, '0, '0, '0, '0);

    // Random traffic; master holds its request until granted
    have = 1'b0;
    last_acc = 1'b0;
    repeat (500) begin
      if (!have || last_acc) begin
        have = ($urandom_range(0, 3) != 0);
        ra = $urandom;
        ra[13:10] = 4'(idxs[$urandom_range(0, 7)]);
        rid = 5'($urandom);
      end
      rrv = '0;
      if (mq.size() > 0 && mq[0].tgt != ERR_T && $urandom_range(0, 2) != 0) rrv[mq[0].tgt] = 1'b1;
      cycle(have, ra, rid, 11'($urandom), rrv);
    end
    while (mq.size() > 0) begin
      rrv = '0;
      if (mq[0].tgt != ERR_T) rrv[mq[0].tgt] = 1'b1;
      cycle(1'b0, '0, '0, '0, rrv);
    end

    // Reset mid-flight, then a late response is a protocol error
    cycle(1'b1, A6, 5'd1, 11'h040, '0);
    cycle(1'b1, A6, 5'd2, 11'h040, '0);
    do_reset();
    check_val("t6_cnt", outstanding_o, 0);
    cycle(1'b0, '0, '0, '0, 11'h040);
    cycle(1'b0, '0, '0, '0, '0);
    check_val("t6_proto", proto_err_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
